hazard_flush_ctrl: RTL

//  Central controller for the ID/EX pipeline register and the stages around it.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/fwd_unit.sv | 22 ++
 rtl/hazard_flush_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and forwarding selects for the pipeline controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MDWAIT  = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // The youngest producer wins, so EX is tested before MEM; $0 never forwards.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic       src_used,
    input logic [4:0] ex_rw,
    input logic       ex_wb,
    input logic [4:0] mem_rw,
    input logic       mem_wb
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (src_used && ex_wb && (ex_rw != 5'd0) && (ex_rw == src)) begin
      sel = FWD_EXMEM;
    end else if (src_used && mem_wb && (mem_rw != 5'd0) && (mem_rw == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - combinational EX operand forwarding selects
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic [4:0] i_ex_Rw,
  input  logic       i_ex_wb,
  input  logic [4:0] i_mem_Rw,
  input  logic       i_mem_wb,
  output logic [1:0] o_fwdA,
  output logic [1:0] o_fwdB
);

  always_comb begin
    o_fwdA = fwd_select(i_id_rs, i_id_use_rs, i_ex_Rw, i_ex_wb, i_mem_Rw, i_mem_wb);
    o_fwdB = fwd_select(i_id_rt, i_id_use_rt, i_ex_Rw, i_ex_wb, i_mem_Rw, i_mem_wb);
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - load-use / mul-div stall and exception flush sequencing around ID/EX
module hazard_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MD_TIMEOUT   = 64,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic [4:0]       i_ex_Rw,
  input  logic             i_ex_memrd,
  input  logic             i_ex_wb,
  input  logic [4:0]       i_mem_Rw,
  input  logic             i_mem_wb,
  input  logic             i_md_start,
  input  logic             i_md_busy,
  input  logic             i_exception,
  input  logic             i_mtc0,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_pc_exc,
  output logic [1:0]       o_fwdA,
  output logic [1:0]       o_fwdB,
  output logic             o_md_timeout,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WC_W = $clog2(MD_TIMEOUT);
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(MD_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             pc_exc_q, pc_exc_d;
  logic             md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       stall, flush, pc_stall;
  logic       ld_hit, md_hit, flush_req;
  logic [1:0] fwd_a, fwd_b;

  fwd_unit u_fwd (
    .i_id_rs     (i_id_rs),
    .i_id_rt     (i_id_rt),
    .i_id_use_rs (i_id_use_rs),
    .i_id_use_rt (i_id_use_rt),
    .i_ex_Rw     (i_ex_Rw),
    .i_ex_wb     (i_ex_wb),
    .i_mem_Rw    (i_mem_Rw),
    .i_mem_wb    (i_mem_wb),
    .o_fwdA      (fwd_a),
    .o_fwdB      (fwd_b)
  );

  always_comb begin
    ld_hit    = i_ex_memrd && (i_ex_Rw != 5'd0) &&
                ((i_id_use_rs && (i_ex_Rw == i_id_rs)) || (i_id_use_rt && (i_ex_Rw == i_id_rt)));
    md_hit    = i_md_start && i_md_busy;
    flush_req = i_exception || i_mtc0;

    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    pc_exc_d     = 1'b0;
    md_timeout_d = md_timeout_q;
    stall        = 1'b0;
    flush        = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
          pc_exc_d    = i_exception;
        end else if (md_hit) begin
          state_d    = ST_MDWAIT;
          wait_cnt_d = '0;
          stall      = 1'b1;
        end else if (ld_hit) begin
          state_d = ST_LDSTALL;
          stall   = 1'b1;
        end
      end
      ST_LDSTALL: begin
        stall = 1'b1;
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
          pc_exc_d    = i_exception;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MDWAIT: begin
        // Release in the same cycle busy drops so no extra bubble is inserted.
        stall = i_md_busy;
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
          pc_exc_d    = i_exception;
        end else if (!i_md_busy) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d      = ST_RUN;
          md_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (i_exception) begin
          flush_cnt_d = FLUSH_LOAD;
          pc_exc_d    = 1'b1;
        end else if (flush_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Reset must silence the combinational detect path too, not just the flops.
    pc_stall     = stall && !i_rst;
    stall_cnt_d  = stall_cnt_q + CNT_W'(pc_stall);
    o_pc_stall   = pc_stall;
    o_ifid_stall = pc_stall;
    o_idex_flush = (stall || flush) && !i_rst;
    o_ifid_flush = flush && !i_rst;
    o_fwdA       = i_rst ? FWD_REG : fwd_a;
    o_fwdB       = i_rst ? FWD_REG : fwd_b;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_RUN;
      flush_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      pc_exc_q     <= 1'b0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      pc_exc_q     <= pc_exc_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign o_pc_exc     = pc_exc_q;
  assign o_md_timeout = md_timeout_q;
  assign o_stall_cnt  = stall_cnt_q;

endmodule
